bus_source_driver: RTL



---
 rtl/bus_source_driver.sv | 92 +++++++++
 1 files changed

// File: rtl/bus_source_driver.sv
// Bus source mux: on each slow strobe, captures the lowest-index enabled source; 1-CLK latency, holds until next strobe, no backpressure.
// Define BUS_CONFLICT_CHECK_EN to flag multi-driver strobes on the sticky BUS_ERR (cleared by ERR_CLR); otherwise BUS_ERR is 0.
module bus_source_driver #(
  parameter int N_SRC = 8,
  parameter int WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SLOW_CLOCK_STRB,
  input  logic [N_SRC*WIDTH-1:0] SRC_DATA,
  input  logic [N_SRC-1:0]       OUT_EN,
  input  logic                   BYTE_EN,
  input  logic                   ERR_CLR,
  output logic [WIDTH-1:0]       BUS,
  output logic                   BUS_VALID,
  output logic [3:0]             BUS_SRC,
  output logic                   BUS_ERR,
  output logic [7:0]             XFER_CNT
);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] bus_q;
  logic [3:0]       src_q;
  logic [7:0]       cnt_q;
  logic             err_q;

  logic [3:0]       sel_idx_d;
  logic [WIDTH-1:0] sel_word_d;
  logic [WIDTH-1:0] bus_d;

  // Scan downward so the lowest set index is the last one written and wins.
  always_comb begin
    sel_idx_d  = '0;
    sel_word_d = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (OUT_EN[i]) begin
        sel_idx_d  = 4'(i);
        sel_word_d = SRC_DATA[i*WIDTH +: WIDTH];
      end
    end
    bus_d = BYTE_EN ? {{(WIDTH-8){1'b0}}, sel_word_d[7:0]} : sel_word_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bus_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else if (SLOW_CLOCK_STRB) begin
      if (|OUT_EN) begin
        state_q <= DRIVE;
        bus_q   <= bus_d;
        src_q   <= sel_idx_d;
        cnt_q   <= cnt_q + 8'd1;
      end else begin
        state_q <= IDLE;
        bus_q   <= '0;
        src_q   <= '0;
      end
    end
  end

`ifdef BUS_CONFLICT_CHECK_EN
  logic conflict_d;
  assign conflict_d = (OUT_EN & (OUT_EN - 1'b1)) != '0;

  // A new conflict on the same edge as ERR_CLR keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (SLOW_CLOCK_STRB && conflict_d) begin
      err_q <= 1'b1;
    end else if (ERR_CLR) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign err_q          = 1'b0;
`endif

  assign BUS       = bus_q;
  assign BUS_VALID = (state_q == DRIVE);
  assign BUS_SRC   = src_q;
  assign BUS_ERR   = err_q;
  assign XFER_CNT  = cnt_q;

endmodule
